hilo_div_unit: RTL and testbench

- Iterative 32-bit radix-2 divider for DIV/DIVU in the EX stage.
- Consumes the decoded MulDiv/div request that the pipeline controller carries D->E.
- Returns a stall request to the hazard logic, which holds stallE/stallPC/stallF/stallD while the unit is busy.
- Delivers quotient and remainder for the HI/LO write-back path (LO = quotient, HI = remainder).

---
 rtl/hilo_div_unit.sv | 106 ++++++++++
 tb/tb_hilo_div_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hilo_div_unit.sv
// rtl/hilo_div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU feeding HI/LO
module hilo_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             stall_req,
    output logic             valid,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT            state, stateNext;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo, rem, divisor;
    logic             signQ, signR;

    logic             negA, negB, accept, lastStep, fits;
    logic [WIDTH-1:0] absA, absB, newQuo, newRem;
    logic [WIDTH:0]   remShift, diff;

    assign negA   = signed_div & opa[WIDTH-1];
    assign negB   = signed_div & opb[WIDTH-1];
    assign absA   = negA ? -opa : opa;
    assign absB   = negB ? -opb : opb;
    assign accept = (state == IDLE) & start & ~cancel;
    assign lastStep = (state == BUSY) & (count == CW'(WIDTH - 1));

    // Shifted remainder needs one extra bit: divisors above 2^(WIDTH-1) can overflow it.
    assign remShift = {rem, quo[WIDTH-1]};
    assign diff     = remShift - {1'b0, divisor};
    assign fits     = ~diff[WIDTH];
    assign newRem   = fits ? diff[WIDTH-1:0] : remShift[WIDTH-1:0];
    assign newQuo   = {quo[WIDTH-2:0], fits};

    assign stall_req = rst & ~cancel & (((state == IDLE) & start) | (state == BUSY));
    assign valid     = (state == DONE) & ~cancel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = (opb == '0) ? DONE : BUSY;
            BUSY:    if (lastStep) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (cancel) stateNext = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            signQ   <= 1'b0;
            signR   <= 1'b0;
            lo      <= '0;
            hi      <= '0;
        end else if (!cancel) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo     <= absA;
                        divisor <= absB;
                        rem     <= '0;
                        count   <= '0;
                        signQ   <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        signR   <= negA;
                        if (opb == '0) begin
                            lo <= '1;
                            hi <= opa;
                        end
                    end
                end
                BUSY: begin
                    quo   <= newQuo;
                    rem   <= newRem;
                    count <= count + 1'b1;
                    // Final step writes the sign-corrected result straight into HI/LO.
                    if (lastStep) begin
                        lo <= signQ ? -newQuo : newQuo;
                        hi <= signR ? -newRem : newRem;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_div_unit.sv
// tb/tb_hilo_div_unit.sv - directed and random checks of hilo_div_unit against an arithmetic model
module tb_hilo_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        signedDiv = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        stallReq, valid;
    logic [31:0] lo, hi;

    int          nVec = 0;
    int          nErr = 0;
    logic [31:0] expLo = '0;
    logic [31:0] expHi = '0;

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signedDiv),
        .opa(opa), .opb(opb), .cancel(cancel),
        .stall_req(stallReq), .valid(valid), .lo(lo), .hi(hi)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
        int          cyc, stalls;
        bit          got;
        logic [31:0] q, r;
        model(a, b, s, q, r);
        @(posedge clk); #1;
        check({tag, "/idle_valid"}, {31'b0, valid}, 32'd0);
        check({tag, "/hold_lo"}, lo, expLo);
        check({tag, "/hold_hi"}, hi, expHi);
        start = 1'b1; signedDiv = s; opa = a; opb = b;
        #1;
        stalls = stallReq ? 1 : 0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (stallReq) stalls++;
            else start = 1'b0;
            if (valid) got = 1'b1;
        end
        start = 1'b0;
        check({tag, "/latency"}, cyc, (b == 0) ? 32'd1 : 32'd33);
        check({tag, "/stall_cycles"}, stalls, (b == 0) ? 32'd1 : 32'd33);
        check({tag, "/lo"}, lo, q);
        check({tag, "/hi"}, hi, r);
        expLo = q;
        expHi = r;
    endtask

    initial begin
        int          pulses;
        logic [31:0] ra, rb;
        logic        rs;

        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        #1;
        check("reset/stall", {31'b0, stallReq}, 32'd0);
        check("reset/valid", {31'b0, valid}, 32'd0);
        check("reset/lo", lo, 32'd0);
        check("reset/hi", hi, 32'd0);
        start = 1'b0;
        rst = 1'b1;

        runDiv(32'd100, 32'd7, 1'b0, "udiv_100_7");
        runDiv(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv_m7_2");
        runDiv(32'd7, 32'hFFFF_FFFE, 1'b1, "sdiv_7_m2");
        runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "sdiv_ovf");
        runDiv(32'h0000_1234, 32'd0, 1'b0, "div_zero");
        runDiv(32'hFFFF_FFF0, 32'd0, 1'b1, "sdiv_zero");
        runDiv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "udiv_max");

        // Cancel at cycle 10 of a 100/7 divide
        @(posedge clk); #1;
        start = 1'b1; signedDiv = 1'b0; opa = 32'd100; opb = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        cancel = 1'b1;
        #1;
        check("cancel/stall", {31'b0, stallReq}, 32'd0);
        check("cancel/valid", {31'b0, valid}, 32'd0);
        @(posedge clk); #1;
        check("cancel_start/stall", {31'b0, stallReq}, 32'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
        start = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        check("cancel/no_valid", pulses, 32'd0);
        check("cancel/lo_kept", lo, expLo);
        check("cancel/hi_kept", hi, expHi);
        runDiv(32'd9, 32'd3, 1'b0, "after_cancel");

        // Reset at cycle 5 of a divide
        @(posedge clk); #1;
        start = 1'b1; signedDiv = 1'b0; opa = 32'd100; opb = 32'd7;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("midreset/lo", lo, 32'd0);
        check("midreset/hi", hi, 32'd0);
        check("midreset/valid", {31'b0, valid}, 32'd0);
        check("midreset/stall", {31'b0, stallReq}, 32'd0);
        expLo = '0;
        expHi = '0;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        runDiv(32'd1000, 32'd10, 1'b0, "after_reset");

        runDiv(32'd50, 32'd5, 1'b0, "b2b_first");
        runDiv(32'hFFFF_FFFF, 32'd16, 1'b0, "b2b_second");

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = -($urandom_range(1, 15));
                3: rb = $urandom | 32'h8000_0000;
                default: rb = $urandom;
            endcase
            runDiv(ra, rb, rs, $sformatf("rand%0d", i));
        end

        @(posedge clk); #1;
        check("final/valid", {31'b0, valid}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
